// File: rtl/t_vga_v1_buttons.sv
// t_vga_v1_buttons: debounced pushbutton/switch input port with Avalon-MM register access,
// edge capture (write-1-to-clear) and a masked level interrupt.
`default_nettype none

module t_vga_v1_buttons #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CAPTURE_EDGE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, deb, deb_d;
  logic [WIDTH-1:0] irqmask, edgecap, edge_hit, clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Released buttons read high, so the whole input path resets to ones; this keeps
  // deb and deb_d equal and no edge can be seen from the reset itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '1;
      sync2   <= '1;
      deb     <= '1;
      deb_d   <= '1;
      irqmask <= '0;
      edgecap <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      // A new edge overrides a simultaneous software clear of the same bit.
      edgecap <= (edgecap & ~clr) | edge_hit;
    end
  end

  generate
    if (CAPTURE_EDGE == 0) begin : g_fall
      assign edge_hit = deb_d & ~deb;
    end else if (CAPTURE_EDGE == 1) begin : g_rise
      assign edge_hit = ~deb_d & deb;
    end else begin : g_any
      assign edge_hit = deb_d ^ deb;
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = deb;
      2'd2:    readdata[WIDTH-1:0] = irqmask;
      2'd3:    readdata[WIDTH-1:0] = edgecap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

`default_nettype wire

// File: tb/tb_t_vga_v1_buttons.sv
// tb_t_vga_v1_buttons: directed self-checking bench, DEBOUNCE_CYCLES=4, WIDTH=4, falling edge.
`default_nettype none

module tb_t_vga_v1_buttons;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  t_vga_v1_buttons #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CAPTURE_EDGE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;
    tick(2);
    reset = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_data", 2'd0, 32'hF);
    chk_rd("rst_addr1", 2'd1, 32'h0);
    chk_rd("rst_mask", 2'd2, 32'h0);
    chk_rd("rst_ecap", 2'd3, 32'h0);

    // Held falling change on bit0: visible after 6 edges, captured one edge later
    in_port = 4'hE;
    tick(5);
    chk_rd("lat_edge5", 2'd0, 32'hF);
    tick(1);
    chk_rd("lat_edge6", 2'd0, 32'hE);
    chk_rd("ecap_edge6", 2'd3, 32'h0);
    tick(1);
    chk_rd("ecap_edge7", 2'd3, 32'h1);
    check("irq_unmasked", {31'd0, irq}, 32'd0);

    wr(2'd2, 32'h1, 1'b1);
    check("irq_masked", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1, 1'b1);
    chk_rd("ecap_clr", 2'd3, 32'h0);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // Rising edge is debounced but not captured
    in_port = 4'hF;
    tick(8);
    chk_rd("rise_data", 2'd0, 32'hF);
    chk_rd("rise_ecap", 2'd3, 32'h0);

    // 3-cycle glitch is filtered
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(8);
    chk_rd("glitch_data", 2'd0, 32'hF);
    chk_rd("glitch_ecap", 2'd3, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Software clear coincides with the bit1 capture edge: set wins
    in_port = 4'hD;
    tick(6);
    chk_rd("b1_data", 2'd0, 32'hD);
    wr(2'd3, 32'h2, 1'b1);
    chk_rd("set_wins", 2'd3, 32'h2);
    check("irq_b1_unmasked", {31'd0, irq}, 32'd0);
    in_port = 4'hF;
    tick(8);
    wr(2'd3, 32'h2, 1'b1);
    chk_rd("b1_clr", 2'd3, 32'h0);

    // Read-only / reserved writes and width truncation
    wr(2'd0, 32'hFFFF_FFFF, 1'b1);
    wr(2'd1, 32'hFFFF_FFFF, 1'b1);
    chk_rd("ro_data", 2'd0, 32'hF);
    chk_rd("ro_addr1", 2'd1, 32'h0);
    chk_rd("ro_mask", 2'd2, 32'h1);
    chk_rd("ro_ecap", 2'd3, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF, 1'b1);
    chk_rd("mask_upper0", 2'd2, 32'hF);
    wr(2'd2, 32'h0, 1'b0);
    chk_rd("cs_low_ignored", 2'd2, 32'hF);

    // Reset in the middle of a pending debounce
    in_port = 4'hE;
    tick(4);
    reset = 1'b1;
    in_port = 4'hF;
    tick(1);
    reset = 1'b0;
    tick(8);
    chk_rd("midrst_data", 2'd0, 32'hF);
    chk_rd("midrst_ecap", 2'd3, 32'h0);
    chk_rd("midrst_mask", 2'd2, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'd0);

    // Inputs held low through reset release: normal debounce, then falling capture
    reset = 1'b1;
    in_port = 4'h0;
    tick(3);
    reset = 1'b0;
    chk_rd("lowrst_data", 2'd0, 32'hF);
    chk_rd("lowrst_ecap", 2'd3, 32'h0);
    tick(5);
    chk_rd("lowrst_edge5", 2'd0, 32'hF);
    tick(1);
    chk_rd("lowrst_edge6", 2'd0, 32'h0);
    tick(1);
    chk_rd("lowrst_ecap7", 2'd3, 32'hF);
    wr(2'd2, 32'h8, 1'b1);
    check("lowrst_irq", {31'd0, irq}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
